// File: rtl/button_debounce_intr.sv
// Button conditioning: two-flop synchroniser, per-button debounce FSM with press/release
// pulses, and a fixed-length interrupt pulse generated from the designated button.
module button_debounce_intr #(
    parameter int N_BTN      = 5,
    parameter int DB_COUNT   = 500000,
    parameter int INTR_IDX   = 4,
    parameter int INTR_PULSE = 2
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             intr
);

    localparam int CNT_W  = $clog2(DB_COUNT + 1);
    localparam int ICNT_W = $clog2(INTR_PULSE + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DB_COUNT - 1);
    localparam logic [ICNT_W-1:0] ICNT_LOAD = ICNT_W'(INTR_PULSE);
    localparam logic [ICNT_W-1:0] ICNT_ONE  = ICNT_W'(1);

    typedef enum logic [1:0] {
        LOW,
        WAIT_HIGH,
        HIGH,
        WAIT_LOW
    } state_t;

    logic [N_BTN-1:0]  sync_p0;
    logic [N_BTN-1:0]  sync_p1;
    state_t            state [N_BTN];
    logic [CNT_W-1:0]  cnt   [N_BTN];
    logic [N_BTN-1:0]  press_evt;
    logic [ICNT_W-1:0] intr_cnt;
    logic [ICNT_W-1:0] intr_cnt_nxt;

    // Stage p0/p1: metastability synchroniser
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce FSMs: the counter restarts on every entry to a WAIT state
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N_BTN; i++) begin
                state[i] <= LOW;
                cnt[i]   <= '0;
            end
            btn_db      <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                case (state[i])
                    LOW: begin
                        if (sync_p1[i]) begin
                            state[i] <= WAIT_HIGH;
                            cnt[i]   <= '0;
                        end
                    end
                    WAIT_HIGH: begin
                        if (!sync_p1[i]) begin
                            state[i] <= LOW;
                        end else if (cnt[i] == CNT_MAX) begin
                            state[i]     <= HIGH;
                            btn_db[i]    <= 1'b1;
                            btn_press[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                    HIGH: begin
                        if (!sync_p1[i]) begin
                            state[i] <= WAIT_LOW;
                            cnt[i]   <= '0;
                        end
                    end
                    WAIT_LOW: begin
                        if (sync_p1[i]) begin
                            state[i] <= HIGH;
                        end else if (cnt[i] == CNT_MAX) begin
                            state[i]       <= LOW;
                            btn_db[i]      <= 1'b0;
                            btn_release[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                    default: state[i] <= LOW;
                endcase
            end
        end
    end

    // Press about to be accepted on this edge; lets intr rise together with btn_press
    always_comb begin
        press_evt = '0;
        for (int i = 0; i < N_BTN; i++) begin
            press_evt[i] = (state[i] == WAIT_HIGH) && sync_p1[i] && (cnt[i] == CNT_MAX);
        end
    end

    // A press reloads only when idle or on the final cycle of the current pulse
    always_comb begin
        intr_cnt_nxt = intr_cnt;
        if (press_evt[INTR_IDX] && (intr_cnt <= ICNT_ONE)) begin
            intr_cnt_nxt = ICNT_LOAD;
        end else if (intr_cnt != '0) begin
            intr_cnt_nxt = intr_cnt - ICNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            intr_cnt <= '0;
            intr     <= 1'b0;
        end else begin
            intr_cnt <= intr_cnt_nxt;
            intr     <= (intr_cnt_nxt != '0);
        end
    end

endmodule
